// File: rtl/pc_sequencer.sv
// Program counter and next-PC selection for the MIPS core: branches, jumps, JR,
// external and misaligned-JR traps with EPC/eret, and a retired-instruction counter.
module pc_sequencer #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [31:0]       TRAP_VECTOR = 32'h0000_0080,
    parameter int                CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch,
    input  logic              branch_not,
    input  logic              zero,
    input  logic              jump,
    input  logic              jal,
    input  logic              jump_r,
    input  logic [31:0]       imm_sext,
    input  logic [25:0]       jtarget,
    input  logic [ADDR_W-1:0] rs_data,
    input  logic              trap,
    input  logic              eret,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] link_addr,
    output logic [ADDR_W-1:0] epc,
    output logic [1:0]        cause,
    output logic              trap_taken,
    output logic [CNT_W-1:0]  retired
);

    localparam logic [ADDR_W-1:0] TRAP_PC = TRAP_VECTOR[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_EXT  = 2'd1;
    localparam logic [1:0] CAUSE_MIS  = 2'd2;

    logic [31:0]       imm_shift;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] j_target;
    logic              taken;
    logic              mis_jr;
    logic              jr_trap;
    logic              retire;

    assign pc_plus4  = pc + PC_STEP;
    assign link_addr = pc_plus4;
    assign imm_shift = imm_sext << 2;
    assign br_target = pc_plus4 + imm_shift[ADDR_W-1:0];

    // J/JAL keep the upper region bits of the delay-slot address when they exist.
    generate
        if (ADDR_W > 28) begin : g_j_region
            assign j_target = {pc_plus4[ADDR_W-1:28], jtarget, 2'b00};
        end else begin : g_j_flat
            logic [27:0] j_full;
            assign j_full   = {jtarget, 2'b00};
            assign j_target = j_full[ADDR_W-1:0];
        end
    endgenerate

    assign taken   = (branch & zero) | (branch_not & ~zero);
    assign mis_jr  = jump_r & (rs_data[1:0] != 2'b00);
    // The misaligned-JR trap only fires when nothing of higher priority redirects.
    assign jr_trap = mis_jr & ~jump & ~taken & ~jal;
    assign retire  = ~stall & ~trap & ~eret & ~jr_trap;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            epc        <= '0;
            cause      <= CAUSE_NONE;
            trap_taken <= 1'b0;
            retired    <= '0;
        end else begin
            trap_taken <= 1'b0;
            if (trap) begin
                pc         <= TRAP_PC;
                epc        <= pc;
                cause      <= CAUSE_EXT;
                trap_taken <= 1'b1;
            end else if (eret) begin
                pc    <= epc;
                cause <= CAUSE_NONE;
            end else if (stall) begin
                pc <= pc;
            end else if (jump) begin
                pc <= j_target;
            end else if (taken) begin
                pc <= br_target;
            end else if (jal) begin
                pc <= j_target;
            end else if (jump_r & ~mis_jr) begin
                pc <= rs_data;
            end else if (jump_r) begin
                pc         <= TRAP_PC;
                epc        <= pc;
                cause      <= CAUSE_MIS;
                trap_taken <= 1'b1;
            end else begin
                pc <= pc_plus4;
            end
            if (retire) begin
                retired <= retired + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a 32-bit instance plus a 16-bit/4-bit-counter
// instance sharing the same stimulus, checked against hand-computed values.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst, stall, branch, branch_not, zero, jump, jal, jump_r, trap, eret;
    logic [31:0] imm_sext;
    logic [25:0] jtarget;
    logic [31:0] rs_data;
    logic [15:0] rs_data16;

    logic [31:0] pc, pc_plus4, link_addr, epc;
    logic [1:0]  cause;
    logic        trap_taken;
    logic [31:0] retired;

    logic [15:0] pc16, pc_plus4_16, link16, epc16;
    logic [1:0]  cause16;
    logic        trap_taken16;
    logic [3:0]  retired16;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] r0;

    assign rs_data16 = rs_data[15:0];

    always #5 clk = ~clk;

    pc_sequencer #(.ADDR_W(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch), .branch_not(branch_not),
        .zero(zero), .jump(jump), .jal(jal), .jump_r(jump_r), .imm_sext(imm_sext),
        .jtarget(jtarget), .rs_data(rs_data), .trap(trap), .eret(eret),
        .pc(pc), .pc_plus4(pc_plus4), .link_addr(link_addr), .epc(epc), .cause(cause),
        .trap_taken(trap_taken), .retired(retired)
    );

    pc_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000), .CNT_W(4)) dut16 (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch), .branch_not(branch_not),
        .zero(zero), .jump(jump), .jal(jal), .jump_r(jump_r), .imm_sext(imm_sext),
        .jtarget(jtarget), .rs_data(rs_data16), .trap(trap), .eret(eret),
        .pc(pc16), .pc_plus4(pc_plus4_16), .link_addr(link16), .epc(epc16), .cause(cause16),
        .trap_taken(trap_taken16), .retired(retired16)
    );

    task automatic clear_inputs();
        rst = 1'b0; stall = 1'b0; branch = 1'b0; branch_not = 1'b0; zero = 1'b0;
        jump = 1'b0; jal = 1'b0; jump_r = 1'b0; trap = 1'b0; eret = 1'b0;
        imm_sext = '0; jtarget = '0; rs_data = '0;
    endtask

    // Inputs are set before the edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic jr_to(input logic [31:0] addr);
        jump_r = 1'b1; rs_data = addr;
        step();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1; stall = 1'b1; trap = 1'b1;
        step();
        step();
        n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        n_cmp++; if (epc !== 32'h0) begin n_fail++; $display("FAIL reset_epc got=%h exp=%h", epc, 32'h0); end
        n_cmp++; if (cause !== 2'd0) begin n_fail++; $display("FAIL reset_cause got=%0d exp=0", cause); end
        n_cmp++; if (trap_taken !== 1'b0) begin n_fail++; $display("FAIL reset_trap_taken got=%b exp=0", trap_taken); end
        n_cmp++; if (retired !== 32'd0) begin n_fail++; $display("FAIL reset_retired got=%0d exp=0", retired); end
        n_cmp++; if (pc16 !== 16'h0) begin n_fail++; $display("FAIL reset_pc16 got=%h exp=0000", pc16); end
        clear_inputs();
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (pc !== exp_pc[i]) begin n_fail++; $display("FAIL seq_pc%0d got=%h exp=%h", i, pc, exp_pc[i]); end
        end
        n_cmp++; if (retired !== 32'd3) begin n_fail++; $display("FAIL seq_retired got=%0d exp=3", retired); end
        n_cmp++; if (pc_plus4 !== 32'h10) begin n_fail++; $display("FAIL seq_pc_plus4 got=%h exp=%h", pc_plus4, 32'h10); end
    endtask

    task automatic test_branch();
        jr_to(32'h0040_0010);
        n_cmp++; if (pc !== 32'h0040_0010) begin n_fail++; $display("FAIL jr_aligned got=%h exp=%h", pc, 32'h0040_0010); end
        branch = 1'b1; zero = 1'b1; imm_sext = 32'hFFFF_FFFC;
        step(); clear_inputs();
        n_cmp++; if (pc !== 32'h0040_0004) begin n_fail++; $display("FAIL beq_taken got=%h exp=%h", pc, 32'h0040_0004); end
        jr_to(32'h0040_0010);
        branch = 1'b1; zero = 1'b0; imm_sext = 32'hFFFF_FFFC;
        step(); clear_inputs();
        n_cmp++; if (pc !== 32'h0040_0014) begin n_fail++; $display("FAIL beq_not_taken got=%h exp=%h", pc, 32'h0040_0014); end
        jr_to(32'h0040_0010);
        branch_not = 1'b1; zero = 1'b0; imm_sext = 32'hFFFF_FFFC;
        step(); clear_inputs();
        n_cmp++; if (pc !== 32'h0040_0004) begin n_fail++; $display("FAIL bne_taken got=%h exp=%h", pc, 32'h0040_0004); end
        branch_not = 1'b1; zero = 1'b1; imm_sext = 32'h0000_0010;
        step(); clear_inputs();
        n_cmp++; if (pc !== 32'h0040_0008) begin n_fail++; $display("FAIL bne_not_taken got=%h exp=%h", pc, 32'h0040_0008); end
    endtask

    task automatic test_jump();
        jr_to(32'h1000_0000);
        jal = 1'b1; jtarget = 26'h000_0040;
        #1;
        n_cmp++; if (link_addr !== 32'h1000_0004) begin n_fail++; $display("FAIL jal_link got=%h exp=%h", link_addr, 32'h1000_0004); end
        step(); clear_inputs();
        n_cmp++; if (pc !== 32'h1000_0100) begin n_fail++; $display("FAIL jal_target got=%h exp=%h", pc, 32'h1000_0100); end
        // jump outranks a taken branch
        jump = 1'b1; jtarget = 26'h000_0200; branch = 1'b1; zero = 1'b1; imm_sext = 32'h0000_0004;
        step(); clear_inputs();
        n_cmp++; if (pc !== 32'h1000_0800) begin n_fail++; $display("FAIL jump_over_branch got=%h exp=%h", pc, 32'h1000_0800); end
    endtask

    task automatic test_mis_jr();
        jr_to(32'h0000_0040);
        r0 = retired;
        jump_r = 1'b1; rs_data = 32'h0000_0203;
        step(); clear_inputs();
        n_cmp++; if (pc !== 32'h80) begin n_fail++; $display("FAIL misjr_pc got=%h exp=%h", pc, 32'h80); end
        n_cmp++; if (epc !== 32'h40) begin n_fail++; $display("FAIL misjr_epc got=%h exp=%h", epc, 32'h40); end
        n_cmp++; if (cause !== 2'd2) begin n_fail++; $display("FAIL misjr_cause got=%0d exp=2", cause); end
        n_cmp++; if (trap_taken !== 1'b1) begin n_fail++; $display("FAIL misjr_trap_taken got=%b exp=1", trap_taken); end
        n_cmp++; if (retired !== r0) begin n_fail++; $display("FAIL misjr_retired got=%0d exp=%0d", retired, r0); end
        eret = 1'b1;
        step(); clear_inputs();
        n_cmp++; if (pc !== 32'h40) begin n_fail++; $display("FAIL eret_pc got=%h exp=%h", pc, 32'h40); end
        n_cmp++; if (cause !== 2'd0) begin n_fail++; $display("FAIL eret_cause got=%0d exp=0", cause); end
        n_cmp++; if (trap_taken !== 1'b0) begin n_fail++; $display("FAIL eret_trap_taken got=%b exp=0", trap_taken); end
        n_cmp++; if (retired !== r0) begin n_fail++; $display("FAIL eret_retired got=%0d exp=%0d", retired, r0); end
    endtask

    task automatic test_stall_trap();
        jr_to(32'h0000_0020);
        r0 = retired;
        for (int i = 0; i < 4; i++) begin
            stall = 1'b1; trap = (i == 2);
            step();
            if (i < 2) begin
                n_cmp++; if (pc !== 32'h20) begin n_fail++; $display("FAIL stall_hold%0d got=%h exp=%h", i, pc, 32'h20); end
            end else if (i == 2) begin
                n_cmp++; if (pc !== 32'h80) begin n_fail++; $display("FAIL stall_trap_pc got=%h exp=%h", pc, 32'h80); end
                n_cmp++; if (epc !== 32'h20) begin n_fail++; $display("FAIL stall_trap_epc got=%h exp=%h", epc, 32'h20); end
                n_cmp++; if (cause !== 2'd1) begin n_fail++; $display("FAIL stall_trap_cause got=%0d exp=1", cause); end
                n_cmp++; if (trap_taken !== 1'b1) begin n_fail++; $display("FAIL stall_trap_pulse got=%b exp=1", trap_taken); end
            end else begin
                n_cmp++; if (pc !== 32'h80) begin n_fail++; $display("FAIL stall_after_trap got=%h exp=%h", pc, 32'h80); end
                n_cmp++; if (trap_taken !== 1'b0) begin n_fail++; $display("FAIL stall_pulse_end got=%b exp=0", trap_taken); end
            end
            n_cmp++; if (retired !== r0) begin n_fail++; $display("FAIL stall_retired%0d got=%0d exp=%0d", i, retired, r0); end
        end
        clear_inputs();
        // trap and eret together: trap wins and epc is overwritten with 0x80
        trap = 1'b1; eret = 1'b1;
        step(); clear_inputs();
        n_cmp++; if (epc !== 32'h80) begin n_fail++; $display("FAIL trap_eret_epc got=%h exp=%h", epc, 32'h80); end
        n_cmp++; if (cause !== 2'd1) begin n_fail++; $display("FAIL trap_eret_cause got=%0d exp=1", cause); end
    endtask

    task automatic test_wrap();
        rst = 1'b1; stall = 1'b1;
        step(); clear_inputs();
        n_cmp++; if (cause !== 2'd0) begin n_fail++; $display("FAIL rst_mid_trap_cause got=%0d exp=0", cause); end
        for (int i = 0; i < 17; i++) step();
        n_cmp++; if (retired16 !== 4'd1) begin n_fail++; $display("FAIL cnt4_wrap got=%0d exp=1", retired16); end
        n_cmp++; if (retired !== 32'd17) begin n_fail++; $display("FAIL cnt32_17 got=%0d exp=17", retired); end
        n_cmp++; if (pc16 !== 16'h0044) begin n_fail++; $display("FAIL pc16_seq got=%h exp=0044", pc16); end
        jr_to(32'h0000_FFFC);
        n_cmp++; if (pc16 !== 16'hFFFC) begin n_fail++; $display("FAIL pc16_top got=%h exp=fffc", pc16); end
        step();
        n_cmp++; if (pc16 !== 16'h0000) begin n_fail++; $display("FAIL pc16_wrap got=%h exp=0000", pc16); end
        n_cmp++; if (pc !== 32'h0001_0000) begin n_fail++; $display("FAIL pc32_no_wrap got=%h exp=%h", pc, 32'h0001_0000); end
        jr_to(32'hFFFF_FFFC);
        step();
        n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("FAIL pc32_wrap got=%h exp=%h", pc, 32'h0); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_mis_jr();
        test_stall_trap();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter and next-PC unit for the MIPS core. It replaces the ad-hoc PC register and redirect chain in the single-cycle top level.
- Adds the following over that chain:
  - configurable address width and reset vector
  - stall/hold
  - an external trap and a misaligned-JR trap, both with EPC capture and eret return
  - an architecturally correct J/JAL target
  - a retired-instruction counter
- Sits between control/ALU outputs and instruction memory. It drives the fetch address and the JAL link value.

Parameters:
- ADDR_W, 32, PC width; legal range 16..32.
- RESET_PC, 0, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0080, PC loaded on any trap; truncated to ADDR_W.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC; no instruction retires.
- branch  in  1  beq-class branch.
- branch_not  in  1  bne-class branch.
- zero  in  1  ALU zero flag.
- jump  in  1  J instruction.
- jal  in  1  JAL instruction.
- jump_r  in  1  JR instruction.
- imm_sext  in  32  sign-extended 16-bit immediate.
- jtarget  in  26  instruction bits [25:0].
- rs_data  in  ADDR_W  register rs value, used as the JR target.
- trap  in  1  external trap request.
- eret  in  1  return from trap.
- pc  out  ADDR_W  current fetch address (registered).
- pc_plus4  out  ADDR_W  pc+4, combinational.
- link_addr  out  ADDR_W  value JAL writes to $31; equals pc_plus4.
- epc  out  ADDR_W  exception PC (registered).
- cause  out  2  0 none, 1 external trap, 2 misaligned JR (registered).
- trap_taken  out  1  one-cycle pulse, registered, asserted the cycle after a trap redirect.
- retired  out  CNT_W  count of retired instructions (registered).

Behaviour:
- Reset, synchronous, highest priority: pc=RESET_PC, epc=0, cause=0, trap_taken=0, retired=0.
- Address arithmetic is modulo 2^ADDR_W:
  - pc_plus4 = pc+4.
  - br_target = pc_plus4 + (imm_sext<<2), truncated to ADDR_W.
  - j_target = {pc_plus4[ADDR_W-1:28], jtarget, 2'b00} when ADDR_W>28, otherwise {jtarget,2'b00}[ADDR_W-1:0].
- taken = (branch & zero) | (branch_not & ~zero).
- mis_jr = jump_r & (rs_data[1:0] != 0), evaluated only when jump_r wins priority.
- Next-PC priority at each rising edge, first match wins:
  1. rst.
  2. trap: pc=TRAP_VECTOR, epc=pc, cause=1, trap_taken=1. Honoured even when stall=1.
  3. eret: pc=epc, cause=0. Honoured even when stall=1.
  4. stall: pc, epc and cause hold.
  5. jump: pc=j_target.
  6. taken: pc=br_target.
  7. jal: pc=j_target.
  8. jump_r & ~mis_jr: pc=rs_data.
  9. jump_r & mis_jr: pc=TRAP_VECTOR, epc=pc, cause=2, trap_taken=1.
  10. Otherwise: pc=pc_plus4.
- trap_taken is 0 in every cycle not covered by rule 2 or rule 9 of the previous edge.
- retired:
  - Increments by 1 on each edge where rst=0, stall=0, trap=0, eret=0, and the mis_jr trap is not taken.
  - Wraps from 2^CNT_W-1 to 0.
- Single-cycle latency: the new pc is visible one clock after the deciding inputs are sampled.
- Simultaneous events:
  - trap & eret: trap wins; epc is overwritten with the current pc.
  - Nested trap while executing at TRAP_VECTOR: epc is overwritten; there is no stack.
- Reset mid-stall or mid-trap: reset wins and all state clears.
- Wrap-around: pc=2^ADDR_W-4 with a sequential step gives pc=0, with no flag raised.

Test Plan:
- Reset, then 3 idle cycles with no control asserted -> pc=0,4,8,12; retired=3.
- pc=0x0040_0010, branch=1, zero=1, imm_sext=0xFFFF_FFFC -> pc=0x0040_0004. Same inputs with zero=0 -> pc=0x0040_0014. branch_not=1, zero=0 -> 0x0040_0004.
- pc=0x1000_0000, jal=1, jtarget=0x0000_040 -> pc=0x1000_0100; link_addr=0x1000_0004 in the JAL cycle.
- jump_r=1, rs_data=0x0000_0203 at pc=0x40 -> pc=0x80, epc=0x40, cause=2, trap_taken=1 for one cycle. Then eret -> pc=0x40, cause=0.
- stall=1 for 4 cycles at pc=0x20, with trap asserted on the 3rd stall cycle -> pc holds 0x20 until the trap edge. Then pc=0x80, epc=0x20, retired unchanged across all stall and trap cycles.
- ADDR_W=16 with pc=0xFFFC, sequential step -> pc=0x0000. CNT_W=4, 17 retirements from reset -> retired=1.
